input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable clock cycles required to accept a change; legal range is 2 or more.
REQ-002 SHALL have port clock, input, 1, the single system clock; all flops clock on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port key_raw, input, 10, raw keypad lines, asynchronous, 1 = key pressed, bit n = digit n.
REQ-005 SHALL have ports startn_raw, stopn_raw, clearn_raw, input, 1 each, raw push-buttons, asynchronous, 0 = pressed.
REQ-006 SHALL have port door_closed_raw, input, 1, raw door switch, asynchronous, 1 = closed.
REQ-007 SHALL have port keypad, output, 10, debounced one-hot key code held while the key is accepted, otherwise all zero.
REQ-008 SHALL have port key_strobe, output, 1, one-cycle pulse on the cycle keypad becomes nonzero.
REQ-009 SHALL have ports startn, stopn, clearn, output, 1 each, debounced active-low buttons.
REQ-010 SHALL have port door_closed, output, 1, debounced door state.

Function
REQ-011 SHALL pass every raw input through a 2-flop synchronizer before any other logic.
REQ-012 Each button/door channel SHALL keep a counter that clears whenever the synced input equals the channel output and increments otherwise.
REQ-013 A button/door output SHALL take the synced value on the cycle its counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL clear on that cycle.
REQ-014 Latency from a stable raw change to the output change SHALL be exactly 2+DEBOUNCE_CYCLES cycles; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-015 The keypad FSM SHALL have exactly four states: IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-016 In IDLE, when the synced key vector has exactly one bit set, the FSM SHALL capture that vector, clear its counter and go to DEBOUNCE.
REQ-017 In IDLE, a synced key vector with zero or more than one bit set SHALL keep the FSM in IDLE.
REQ-018 In DEBOUNCE, if the synced vector differs from the captured vector, the FSM SHALL go to RELEASE with the counter cleared.
REQ-019 In DEBOUNCE, if the vectors match, the counter SHALL increment.
REQ-020 On the DEBOUNCE cycle the counter reaches DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED, load keypad with the captured code and pulse key_strobe for one cycle.
REQ-021 In PRESSED, keypad SHALL hold its value while the synced vector equals the captured code.
REQ-022 In PRESSED, any difference (release or an extra key) SHALL clear keypad on the next edge and move the FSM to RELEASE with the counter cleared.
REQ-023 In RELEASE, the counter SHALL increment while the synced vector is all zero and clear on any nonzero cycle.
REQ-024 RELEASE SHALL go to IDLE on the cycle the counter reaches DEBOUNCE_CYCLES-1; no new key is accepted until then.
REQ-025 key_strobe SHALL be asserted only on the PRESSED entry cycle; a held key SHALL never re-strobe.
REQ-026 All counters SHALL be clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap.
REQ-027 Button channels and the keypad FSM SHALL be fully independent; simultaneous events on different channels SHALL each follow their own timing.

Reset
REQ-028 While resetn=0, outputs SHALL be: keypad=0, key_strobe=0, startn=1, stopn=1, clearn=1, door_closed=0.
REQ-029 While resetn=0, synchronizer flops SHALL hold inactive levels (key 0, buttons 1, door 0), counters SHALL be 0 and the FSM SHALL be in IDLE.
REQ-030 Reset asserted mid-debounce or mid-press SHALL abort the operation with no strobe; after release, inputs SHALL be re-qualified from scratch.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Key press: key_raw=10'h008 held 10 cycles -> keypad=10'h008 and key_strobe=1 on cycle 6 after the edge; key_strobe=0 on cycle 7; keypad held until release.
REQ-032 Glitch rejection: startn_raw=0 for 3 cycles then 1 -> startn stays 1 throughout; with 0 held 4+ cycles -> startn=0 at cycle 6.
REQ-033 Two keys: key_raw=10'h003 -> keypad stays 0 and no strobe; during PRESSED on 10'h001, adding bit 1 -> keypad=0 next cycle, no new strobe.
REQ-034 Release bounce: in RELEASE, key_raw toggles 0/1 every 2 cycles, then holds 0 -> FSM returns to IDLE only 4 cycles after the last nonzero synced cycle; a press during bounce is not accepted.
REQ-035 Door: door_closed_raw 0->1 -> door_closed=1 at cycle 6; concurrent stopn_raw press -> stopn=0 on its own independent cycle 6.
REQ-036 Reset mid-DEBOUNCE: resetn=0 at cycle 3 of a key press -> all outputs at reset values, no strobe; after resetn=1 with the key still held -> strobe 6 cycles later.

Source files
------------

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Cleans up the raw front-panel inputs of the controller before the rest of
// the logic sees them. Every raw line is first brought into the clock domain
// through a two-flop synchronizer. After that, each push-button and the door
// switch is filtered by its own debounce counter. The ten keypad lines are
// filtered by a small FSM that accepts only one key at a time and emits a
// single strobe per accepted press.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//
// Ports
//   clock            system clock, all flops use the rising edge
//   resetn           asynchronous active-low reset
//   key_raw[9:0]     raw keypad lines, 1 = pressed, bit n = digit n
//   startn_raw       raw start button, 0 = pressed
//   stopn_raw        raw stop button, 0 = pressed
//   clearn_raw       raw clear button, 0 = pressed
//   door_closed_raw  raw door switch, 1 = closed
//   keypad[9:0]      debounced one-hot key code, zero when no key is accepted
//   key_strobe       one-cycle pulse on the cycle keypad becomes nonzero
//   startn           debounced start button, active low
//   stopn            debounced stop button, active low
//   clearn           debounced clear button, active low
//   door_closed      debounced door state, 1 = closed
// ---------------------------------------------------------------------------
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [9:0] key_raw,
   input  logic       startn_raw,
   input  logic       stopn_raw,
   input  logic       clearn_raw,
   input  logic       door_closed_raw,
   output logic [9:0] keypad,
   output logic       key_strobe,
   output logic       startn,
   output logic       stopn,
   output logic       clearn,
   output logic       door_closed
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_PRE_LAST = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   // Button/door channels are packed as {door, clear, stop, start}.
   // The inactive level is released buttons (1) and an open door (0).
   localparam logic [3:0] BTN_INACTIVE = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } key_state_t;

   logic [9:0]    key_meta;
   logic [9:0]    key_sync;
   logic [3:0]    btn_raw;
   logic [3:0]    btn_meta;
   logic [3:0]    btn_sync;
   logic [3:0]    btn_out;
   logic [CW-1:0] btn_cnt [4];

   key_state_t    state;
   key_state_t    state_next;
   logic [CW-1:0] key_cnt;
   logic [CW-1:0] key_cnt_next;
   logic [9:0]    key_cap;
   logic [9:0]    key_cap_next;
   logic [9:0]    keypad_next;
   logic          strobe_next;

   assign btn_raw = {door_closed_raw, clearn_raw, stopn_raw, startn_raw};

   // Two-flop synchronizers for every raw line. During reset they hold the
   // inactive level so that nothing downstream sees a phantom press when
   // reset is released.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         key_meta <= '0;
         key_sync <= '0;
         btn_meta <= BTN_INACTIVE;
         btn_sync <= BTN_INACTIVE;
      end else begin
         key_meta <= key_raw;
         key_sync <= key_meta;
         btn_meta <= btn_raw;
         btn_sync <= btn_meta;
      end
   end

   // Button and door debouncers. Each channel counts the cycles in which the
   // synchronized level disagrees with the accepted output, and restarts
   // from zero on any agreeing cycle. Once the counter sits at
   // DEBOUNCE_CYCLES-1 with the input still different, the input has
   // differed for DEBOUNCE_CYCLES consecutive cycles, so the output takes
   // the new level and the counter restarts. With the two synchronizer
   // stages this gives a raw-to-output latency of 2+DEBOUNCE_CYCLES.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         btn_out <= BTN_INACTIVE;
         for (int i = 0; i < 4; i++) begin
            btn_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (btn_sync[i] == btn_out[i]) begin
               btn_cnt[i] <= '0;
            end else if (btn_cnt[i] == CNT_LAST) begin
               btn_out[i] <= btn_sync[i];
               btn_cnt[i] <= '0;
            end else begin
               btn_cnt[i] <= btn_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign startn      = btn_out[0];
   assign stopn       = btn_out[1];
   assign clearn      = btn_out[2];
   assign door_closed = btn_out[3];

   // Keypad FSM state register. keypad and key_strobe are registered here
   // so that both outputs are glitch-free flop outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         key_cnt    <= '0;
         key_cap    <= '0;
         keypad     <= '0;
         key_strobe <= 1'b0;
      end else begin
         state      <= state_next;
         key_cnt    <= key_cnt_next;
         key_cap    <= key_cap_next;
         keypad     <= keypad_next;
         key_strobe <= strobe_next;
      end
   end

   // Keypad FSM next-state logic.
   // IDLE captures a single-key vector; the capture cycle already counts as
   // the first stable cycle, so DEBOUNCE promotes to PRESSED on the edge its
   // counter would reach DEBOUNCE_CYCLES-1. That keeps the keypad latency at
   // 2+DEBOUNCE_CYCLES, the same as the buttons.
   // RELEASE has no capture cycle in front of it: it needs DEBOUNCE_CYCLES
   // all-zero cycles after the last nonzero one before returning to IDLE,
   // and any nonzero cycle (bounce or a new key) restarts that wait.
   always_comb begin
      state_next   = state;
      key_cnt_next = key_cnt;
      key_cap_next = key_cap;
      keypad_next  = keypad;
      strobe_next  = 1'b0;

      case (state)
         IDLE: begin
            if ($onehot(key_sync)) begin
               key_cap_next = key_sync;
               key_cnt_next = '0;
               state_next   = DEBOUNCE;
            end
         end

         DEBOUNCE: begin
            if (key_sync != key_cap) begin
               key_cnt_next = '0;
               state_next   = RELEASE;
            end else if (key_cnt == CNT_PRE_LAST) begin
               key_cnt_next = '0;
               keypad_next  = key_cap;
               strobe_next  = 1'b1;
               state_next   = PRESSED;
            end else begin
               key_cnt_next = key_cnt + CNT_ONE;
            end
         end

         PRESSED: begin
            if (key_sync != key_cap) begin
               keypad_next  = '0;
               key_cnt_next = '0;
               state_next   = RELEASE;
            end
         end

         RELEASE: begin
            if (key_sync != '0) begin
               key_cnt_next = '0;
            end else if (key_cnt == CNT_LAST) begin
               key_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               key_cnt_next = key_cnt + CNT_ONE;
            end
         end

         default: begin
            key_cnt_next = '0;
            keypad_next  = '0;
            state_next   = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed, self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; "cycle k" below means 1 ns after
// the k-th rising edge following the input change. Expected values are
// hand-derived from the 2+DEBOUNCE_CYCLES latency rules.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

   logic       clock;
   logic       resetn;
   logic [9:0] key_raw;
   logic       startn_raw;
   logic       stopn_raw;
   logic       clearn_raw;
   logic       door_closed_raw;
   logic [9:0] keypad;
   logic       key_strobe;
   logic       startn;
   logic       stopn;
   logic       clearn;
   logic       door_closed;

   int compared   = 0;
   int mismatched = 0;

   input_conditioner #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock          (clock),
      .resetn         (resetn),
      .key_raw        (key_raw),
      .startn_raw     (startn_raw),
      .stopn_raw      (stopn_raw),
      .clearn_raw     (clearn_raw),
      .door_closed_raw(door_closed_raw),
      .keypad         (keypad),
      .key_strobe     (key_strobe),
      .startn         (startn),
      .stopn          (stopn),
      .clearn         (clearn),
      .door_closed    (door_closed)
   );

   // Free-running 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance n rising edges and land 1 ns after the last one.
   task automatic advance(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drive every raw input at once.
   task automatic apply_stimulus(input logic [9:0] key, input logic st,
                                 input logic sp, input logic cl,
                                 input logic door);
      key_raw         = key;
      startn_raw      = st;
      stopn_raw       = sp;
      clearn_raw      = cl;
      door_closed_raw = door;
   endtask

   // One comparison point.
   task automatic check_output(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      // ---------------- reset state ----------------
      resetn = 1'b0;
      apply_stimulus(10'h000, 1'b1, 1'b1, 1'b1, 1'b0);
      advance(2);
      check_output("rst_keypad", keypad, 10'h000);
      check_output("rst_strobe", {9'd0, key_strobe}, 10'h000);
      check_output("rst_startn", {9'd0, startn}, 10'h001);
      check_output("rst_stopn", {9'd0, stopn}, 10'h001);
      check_output("rst_clearn", {9'd0, clearn}, 10'h001);
      check_output("rst_door", {9'd0, door_closed}, 10'h000);
      resetn = 1'b1;
      advance(2);

      // ---------------- single key press ----------------
      $display("[TB] key press 0x008");
      key_raw = 10'h008;
      advance(5);
      check_output("key_c5_keypad", keypad, 10'h000);
      check_output("key_c5_strobe", {9'd0, key_strobe}, 10'h000);
      advance(1);
      check_output("key_c6_keypad", keypad, 10'h008);
      check_output("key_c6_strobe", {9'd0, key_strobe}, 10'h001);
      advance(1);
      check_output("key_c7_keypad", keypad, 10'h008);
      check_output("key_c7_strobe", {9'd0, key_strobe}, 10'h000);
      advance(3);
      check_output("key_c10_keypad", keypad, 10'h008);
      check_output("key_c10_strobe", {9'd0, key_strobe}, 10'h000);
      key_raw = 10'h000;
      advance(2);
      check_output("key_rel2_keypad", keypad, 10'h008);
      advance(1);
      check_output("key_rel3_keypad", keypad, 10'h000);
      advance(8);

      // ---------------- start button glitch / press ----------------
      $display("[TB] startn glitch and press");
      startn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         advance(1);
         check_output("glitch_startn", {9'd0, startn}, 10'h001);
      end
      startn_raw = 1'b1;
      for (int i = 0; i < 8; i++) begin
         advance(1);
         check_output("glitch_startn_after", {9'd0, startn}, 10'h001);
      end
      startn_raw = 1'b0;
      advance(5);
      check_output("start_c5", {9'd0, startn}, 10'h001);
      advance(1);
      check_output("start_c6", {9'd0, startn}, 10'h000);
      startn_raw = 1'b1;
      advance(5);
      check_output("start_rel_c5", {9'd0, startn}, 10'h000);
      advance(1);
      check_output("start_rel_c6", {9'd0, startn}, 10'h001);

      // ---------------- two keys ----------------
      $display("[TB] two keys");
      key_raw = 10'h003;
      for (int i = 0; i < 10; i++) begin
         advance(1);
         check_output("two_keypad", keypad, 10'h000);
         check_output("two_strobe", {9'd0, key_strobe}, 10'h000);
      end
      key_raw = 10'h000;
      advance(3);
      key_raw = 10'h001;
      advance(5);
      check_output("k1_c5_keypad", keypad, 10'h000);
      advance(1);
      check_output("k1_c6_keypad", keypad, 10'h001);
      check_output("k1_c6_strobe", {9'd0, key_strobe}, 10'h001);
      advance(2);
      key_raw = 10'h003;
      advance(2);
      check_output("extra_c2_keypad", keypad, 10'h001);
      advance(1);
      check_output("extra_c3_keypad", keypad, 10'h000);
      check_output("extra_c3_strobe", {9'd0, key_strobe}, 10'h000);
      for (int i = 0; i < 5; i++) begin
         advance(1);
         check_output("extra_hold_keypad", keypad, 10'h000);
         check_output("extra_hold_strobe", {9'd0, key_strobe}, 10'h000);
      end
      key_raw = 10'h000;
      advance(10);

      // ---------------- release bounce, late press rejected ----------------
      $display("[TB] release bounce");
      key_raw = 10'h004;
      advance(6);
      check_output("b1_keypad", keypad, 10'h004);
      check_output("b1_strobe", {9'd0, key_strobe}, 10'h001);
      key_raw = 10'h000;
      advance(3);
      check_output("b1_rel_keypad", keypad, 10'h000);
      for (int i = 0; i < 4; i++) begin
         key_raw = 10'h004;
         advance(2);
         check_output("bounce_keypad", keypad, 10'h000);
         key_raw = 10'h000;
         advance(2);
         check_output("bounce_strobe", {9'd0, key_strobe}, 10'h000);
      end
      advance(1);
      key_raw = 10'h002;
      for (int i = 0; i < 10; i++) begin
         advance(1);
         check_output("late_keypad", keypad, 10'h000);
         check_output("late_strobe", {9'd0, key_strobe}, 10'h000);
      end
      key_raw = 10'h000;
      advance(10);

      // ---------------- release bounce, first accepted press ----------------
      key_raw = 10'h004;
      advance(6);
      check_output("b2_strobe", {9'd0, key_strobe}, 10'h001);
      key_raw = 10'h000;
      advance(3);
      check_output("b2_rel_keypad", keypad, 10'h000);
      key_raw = 10'h004;
      advance(2);
      key_raw = 10'h000;
      advance(4);
      key_raw = 10'h002;
      advance(5);
      check_output("ok_c5_keypad", keypad, 10'h000);
      advance(1);
      check_output("ok_c6_keypad", keypad, 10'h002);
      check_output("ok_c6_strobe", {9'd0, key_strobe}, 10'h001);
      key_raw = 10'h000;
      advance(10);

      // ---------------- door and concurrent stop ----------------
      $display("[TB] door and stop");
      door_closed_raw = 1'b1;
      advance(2);
      stopn_raw = 1'b0;
      advance(3);
      check_output("door_c5", {9'd0, door_closed}, 10'h000);
      advance(1);
      check_output("door_c6", {9'd0, door_closed}, 10'h001);
      check_output("stop_c4", {9'd0, stopn}, 10'h001);
      advance(1);
      check_output("stop_c5", {9'd0, stopn}, 10'h001);
      advance(1);
      check_output("stop_c6", {9'd0, stopn}, 10'h000);
      check_output("door_hold", {9'd0, door_closed}, 10'h001);
      stopn_raw = 1'b1;
      advance(6);
      check_output("stop_rel_c6", {9'd0, stopn}, 10'h001);

      // ---------------- clear button ----------------
      clearn_raw = 1'b0;
      advance(5);
      check_output("clear_c5", {9'd0, clearn}, 10'h001);
      advance(1);
      check_output("clear_c6", {9'd0, clearn}, 10'h000);
      clearn_raw = 1'b1;
      advance(8);

      // ---------------- reset mid-debounce ----------------
      $display("[TB] reset mid-debounce");
      key_raw = 10'h008;
      advance(3);
      resetn = 1'b0;
      advance(1);
      check_output("mid_rst_keypad", keypad, 10'h000);
      check_output("mid_rst_strobe", {9'd0, key_strobe}, 10'h000);
      check_output("mid_rst_door", {9'd0, door_closed}, 10'h000);
      check_output("mid_rst_startn", {9'd0, startn}, 10'h001);
      advance(1);
      check_output("mid_rst_strobe2", {9'd0, key_strobe}, 10'h000);
      resetn = 1'b1;
      advance(5);
      check_output("post_rst_c5_keypad", keypad, 10'h000);
      check_output("post_rst_c5_strobe", {9'd0, key_strobe}, 10'h000);
      check_output("post_rst_c5_door", {9'd0, door_closed}, 10'h000);
      advance(1);
      check_output("post_rst_c6_keypad", keypad, 10'h008);
      check_output("post_rst_c6_strobe", {9'd0, key_strobe}, 10'h001);
      check_output("post_rst_c6_door", {9'd0, door_closed}, 10'h001);
      advance(1);
      check_output("post_rst_c7_strobe", {9'd0, key_strobe}, 10'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
